// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit for an in-order pipeline.
// MUL/MULHU use shift-add and DIVU/REMU use restoring division. Each
// operation runs one iteration per cycle, and the unit stalls the front of
// the pipeline while it is busy.
// Optional build macro MULDIV_EARLY_OUT_EN: MUL finishes as soon as the
// remaining multiplier bits are all zero.
module muldiv_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_MUL = 2'b00;

  state_e                state_q;
  logic [1:0]            op_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*XLEN-1:0]     acc_q;     // product, or {remainder, dividend/quotient}
  logic [2*XLEN-1:0]     mcand_q;   // left-shifting multiplicand
  logic [XLEN-1:0]       mplier_q;  // right-shifting multiplier, or divisor
  logic                  done_q;
  logic [XLEN-1:0]       result_q;

  logic [2*XLEN-1:0]     acc_d;
  logic [2*XLEN-1:0]     mcand_d;
  logic [XLEN-1:0]       mplier_d;
  logic [XLEN:0]         div_hi;
  logic [XLEN:0]         div_diff;
  logic                  div_ge;
  logic                  last_iter;
  logic                  start_div0;
  logic [XLEN-1:0]       iter_res;

  // One shift-add or restoring-division step on the current datapath state
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    div_hi   = {acc_q[2*XLEN-1:XLEN-1]};
    div_diff = div_hi - {1'b0, mplier_q};
    // The remainder stays below the divisor, so the sign bit of the
    // trial subtraction tells us whether the divisor fits.
    div_ge   = ~div_diff[XLEN];
    if (!op_q[1]) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end else begin
      acc_d = {(div_ge ? div_diff[XLEN-1:0] : div_hi[XLEN-1:0]),
               acc_q[XLEN-2:0], div_ge};
    end
    // The low half holds the MUL product or the quotient.
    // The high half holds the MULHU product or the remainder.
    iter_res = op_q[0] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
`ifdef MULDIV_EARLY_OUT_EN
    last_iter = (cnt_q == CNT_W'(1)) || ((op_q == OP_MUL) && (mplier_d == '0));
`else
    last_iter = (cnt_q == CNT_W'(1));
`endif
  end

  assign start_div0 = op[1] && (src_b == '0);

  // Sequencer FSM together with the datapath registers and the result/done registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q     <= op;
            cnt_q    <= CNT_W'(XLEN);
            acc_q    <= op[1] ? {{XLEN{1'b0}}, src_a} : '0;
            mcand_q  <= {{XLEN{1'b0}}, src_a};
            mplier_q <= src_b;
            if (start_div0) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= op[0] ? src_a : '1;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (last_iter) begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= iter_res;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign stall  = rst_n && (((state_q == S_IDLE) && start) || (state_q == S_CALC));
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vectors, multi-cycle
// corner sequences (flush, reset, start while busy) and random operations
// against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  int stall_bad;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t tbl[16];

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the start cycle to the done cycle
  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] b);
    int n;
    if (o[1] && b == 0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (o == 2'd0) begin
      n = 0;
      for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
      return ((n == 0) ? 1 : n) + 1;
    end
`endif
    n = 33;
    return n;
  endfunction

  // Called just after a falling edge; the request is sampled at the next rising edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1;
    stall_bad = stall ? 0 : 1;
  endtask

  task automatic finish_op(input string name, input logic [31:0] exp_res, input int exp_lat);
    int          got_lat = 0;
    logic [31:0] got_res = '0;
    logic        stall_done = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done) begin
        got_lat = k; got_res = result; stall_done = stall;
        break;
      end
      if (!stall) stall_bad++;
    end
    chk({name, " latency"}, 64'(got_lat), 64'(exp_lat));
    chk({name, " result"}, 64'(got_res), 64'(exp_res));
    chk({name, " stall"}, 64'((stall_bad == 0) && !stall_done), 64'd1);
    @(negedge clk);
    #1;
    chk({name, " pulse/hold"}, {31'd0, done, result}, {32'd0, exp_res});
  endtask

  initial begin
    int          cnt;
    int          lat;
    logic [31:0] res;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    tbl[0]  = '{2'd0, 32'd7,          32'd6,          32'd42};
    tbl[1]  = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    tbl[2]  = '{2'd2, 32'd100,        32'd7,          32'd14};
    tbl[3]  = '{2'd3, 32'd100,        32'd7,          32'd2};
    tbl[4]  = '{2'd2, 32'd5,          32'd0,          32'hFFFF_FFFF};
    tbl[5]  = '{2'd3, 32'd5,          32'd0,          32'd5};
    tbl[6]  = '{2'd0, 32'd3,          32'd2,          32'd6};
    tbl[7]  = '{2'd0, 32'd3,          32'd0,          32'd0};
    tbl[8]  = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1};
    tbl[9]  = '{2'd2, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    tbl[10] = '{2'd3, 32'hFFFF_FFFF,  32'h10,         32'hF};
    tbl[11] = '{2'd1, 32'h8000_0000,  32'd2,          32'd1};
    tbl[12] = '{2'd2, 32'd3,          32'd5,          32'd0};
    tbl[13] = '{2'd3, 32'd3,          32'd5,          32'd3};
    tbl[14] = '{2'd0, 32'd1,          32'h8000_0000,  32'h8000_0000};
    tbl[15] = '{2'd1, 32'd0,          32'h12345,      32'd0};

    // Reset with start held high: stall must stay low
    rst_n = 1'b0; start = 1'b1; flush = 1'b0; op = 2'd0; src_a = 32'h1234; src_b = 32'd5;
    @(negedge clk); #1;
    chk("reset stall", 64'(stall), 64'd0);
    @(negedge clk); #1;
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset stall2", 64'(stall), 64'd0);
    rst_n = 1'b1; start = 1'b0;

    // Directed vectors, issued back-to-back in the cycle after each done
    for (int i = 0; i < 16; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      finish_op($sformatf("vec%0d", i), tbl[i].res, ref_lat(tbl[i].op, tbl[i].b));
    end

    // Flush mid-divide: no done, result holds, new start accepted the next cycle
    issue(2'd2, 32'd100, 32'd7);
    cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); start = 1'b0; #1;
      if (done) cnt++;
      if (k == 10) flush = 1'b1;
    end
    @(negedge clk); flush = 1'b0; #1;
    chk("flush idle stall", 64'(stall), 64'd0);
    chk("flush no done", 64'(cnt + int'(done)), 64'd0);
    chk("flush result hold", 64'(result), 64'd0);
    issue(2'd0, 32'd7, 32'd6);
    finish_op("post-flush mul", 32'd42, ref_lat(2'd0, 32'd6));

    // Reset in the middle of a multiply
    issue(2'd0, 32'd9, 32'd9);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); start = 1'b0; #1;
    end
    rst_n = 1'b0; #1;
    chk("midrst stall", 64'(stall), 64'd0);
    @(negedge clk); #1;
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst result", 64'(result), 64'd0);
    chk("midrst stall2", 64'(stall), 64'd0);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (done) cnt++;
    end
    chk("midrst no done", 64'(cnt), 64'd0);

    // A second start during the calculation is ignored
    issue(2'd2, 32'd1000, 32'd3);
    cnt = 0; lat = 0; res = '0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = (k >= 3 && k <= 6);
      op = 2'd0; src_a = 32'd5; src_b = 32'd5;
      #1;
      if (done) begin
        cnt++;
        if (cnt == 1) begin lat = k; res = result; end
      end
    end
    start = 1'b0;
    chk("busy-start done count", 64'(cnt), 64'd1);
    chk("busy-start latency", 64'(lat), 64'd33);
    chk("busy-start result", 64'(res), 64'd333);

    // Random operations against the reference model
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb);
      finish_op($sformatf("rand%0d op%0d %0h,%0h", i, ro, ra, rb), ref_res(ro, ra, rb),
                ref_lat(ro, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
